// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the writeback/commit slice.
//   - Default widths: DEF_DATA_W, DEF_NREGS, DEF_SQ_W, DEF_CNT_W.
//   - dst_sel(): picks which candidate index becomes the destination.
//   - src_sel(): picks which result source is written back.
// The select functions return enums rather than values, which keeps them
// independent of the data and index widths chosen by each instance.
// -----------------------------------------------------------------------------
package wb_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_NREGS  = 16;
   localparam int DEF_SQ_W   = 2;
   localparam int DEF_CNT_W  = 32;

   typedef enum logic {
      DST_RS = 1'b0,
      DST_RD = 1'b1
   } dst_sel_e;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_sel_e;

   // Loads always target rs; otherwise regdst chooses between rd and rs.
   function automatic dst_sel_e dst_sel(input logic memtoreg, input logic regdst);
      dst_sel_e sel;
      if (memtoreg) begin
         sel = DST_RS;
      end else if (regdst) begin
         sel = DST_RD;
      end else begin
         sel = DST_RS;
      end
      return sel;
   endfunction

   // Loads write back the memory data; everything else writes the ALU result.
   function automatic src_sel_e src_sel(input logic memtoreg);
      src_sel_e sel;
      if (memtoreg) begin
         sel = SRC_MEM;
      end else begin
         sel = SRC_ALU;
      end
      return sel;
   endfunction

endpackage

// File: rtl/wb_regfile_commit_if.sv
// -----------------------------------------------------------------------------
// wb_regfile_commit_if
// Retiring-instruction bundle presented to the writeback stage.
//   wb_valid, wb_regwrite, wb_memtoreg, wb_regdst : beat control
//   wb_rs, wb_rd                                  : candidate destinations
//   wb_alu_result, wb_read_data                   : result sources
// Modports: master (pipeline side, drives), slave (commit stage, receives).
// -----------------------------------------------------------------------------
interface wb_regfile_commit_if #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 4
);
   logic              wb_valid;
   logic              wb_regwrite;
   logic              wb_memtoreg;
   logic              wb_regdst;
   logic [IDX_W-1:0]  wb_rs;
   logic [IDX_W-1:0]  wb_rd;
   logic [DATA_W-1:0] wb_alu_result;
   logic [DATA_W-1:0] wb_read_data;

   modport master (
      output wb_valid, wb_regwrite, wb_memtoreg, wb_regdst,
      output wb_rs, wb_rd, wb_alu_result, wb_read_data
   );

   modport slave (
      input wb_valid, wb_regwrite, wb_memtoreg, wb_regdst,
      input wb_rs, wb_rd, wb_alu_result, wb_read_data
   );
endinterface

// File: rtl/wb_squash_ctr.sv
// -----------------------------------------------------------------------------
// wb_squash_ctr
// Counts down the beats still to be dropped after a taken jump.
//   clk, rst    : clock, synchronous active-high reset
//   accept      : a beat is accepted this cycle (valid and not stalled)
//   squash_set  : load squash_n (wins over a same-cycle decrement)
//   squash_n    : number of following accepted beats to drop
//   busy        : counter nonzero
//   drop        : the beat accepted this cycle is dropped (old counter value)
// -----------------------------------------------------------------------------
module wb_squash_ctr #(
   parameter int SQ_W = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            accept,
   input  logic            squash_set,
   input  logic [SQ_W-1:0] squash_n,
   output logic            busy,
   output logic            drop
);

   logic [SQ_W-1:0] cnt_r;
   logic [SQ_W-1:0] cnt_nxt_s;

   // Busy/drop decode and next count; a load overrides the decrement.
   always_comb begin
      busy      = (cnt_r != {SQ_W{1'b0}});
      drop      = accept && busy;
      cnt_nxt_s = cnt_r;
      if (squash_set) begin
         cnt_nxt_s = squash_n;
      end else if (drop) begin
         cnt_nxt_s = cnt_r - SQ_W'(1);
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {SQ_W{1'b0}};
      end else begin
         cnt_r <= cnt_nxt_s;
      end
   end

endmodule

// File: rtl/wb_regfile_commit.sv
// -----------------------------------------------------------------------------
// wb_regfile_commit
// Writeback/commit stage owning the architectural register file and its
// per-register availability scoreboard.
//   clk, rst                : clock, synchronous active-high reset
//   stall                   : no beat accepted this cycle
//   wb (slave)              : retiring instruction bundle
//   squash_set, squash_n    : drop the next squash_n accepted beats
//   claim_valid, claim_idx  : issue marks a destination pending
//   ra_idx/rb_idx           : read-port indices
//   ra_data/rb_data         : read data, bypassed from a same-cycle commit
//   ra_avail/rb_avail       : availability, bypassed from a same-cycle commit
//   squash_busy             : squash counter nonzero
//   retired_cnt             : committed register writes (wraps)
// Optional build macro WB_TRACE_EN: prints each commit and a register dump.
// -----------------------------------------------------------------------------
module wb_regfile_commit
   import wb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NREGS  = DEF_NREGS,
   parameter int IDX_W  = $clog2(NREGS),
   parameter int SQ_W   = DEF_SQ_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   wb_regfile_commit_if.slave   wb,
   input  logic                 squash_set,
   input  logic [SQ_W-1:0]      squash_n,
   input  logic                 claim_valid,
   input  logic [IDX_W-1:0]     claim_idx,
   input  logic [IDX_W-1:0]     ra_idx,
   input  logic [IDX_W-1:0]     rb_idx,
   output logic [DATA_W-1:0]    ra_data,
   output logic [DATA_W-1:0]    rb_data,
   output logic                 ra_avail,
   output logic                 rb_avail,
   output logic                 squash_busy,
   output logic [CNT_W-1:0]     retired_cnt
);

   logic              accept_s;
   logic              drop_s;
   logic              commit_s;
   logic [IDX_W-1:0]  dest_s;
   logic [DATA_W-1:0] data_s;

   logic [DATA_W-1:0] regs_r [NREGS];
   logic [NREGS-1:0]  avail_r;
   logic [CNT_W-1:0]  retired_cnt_r;

   // Beat acceptance.
   always_comb begin
      accept_s = wb.wb_valid && !stall;
   end

   wb_squash_ctr #(
      .SQ_W (SQ_W)
   ) u_squash (
      .clk        (clk),
      .rst        (rst),
      .accept     (accept_s),
      .squash_set (squash_set),
      .squash_n   (squash_n),
      .busy       (squash_busy),
      .drop       (drop_s)
   );

   // Destination/source selection and commit qualification; reset suppresses
   // the commit so the bypass is also inert during reset.
   always_comb begin
      dest_s = wb.wb_rs;
      data_s = wb.wb_alu_result;
      case (dst_sel(wb.wb_memtoreg, wb.wb_regdst))
         DST_RD:  dest_s = wb.wb_rd;
         DST_RS:  dest_s = wb.wb_rs;
         default: dest_s = wb.wb_rs;
      endcase
      case (src_sel(wb.wb_memtoreg))
         SRC_MEM: data_s = wb.wb_read_data;
         SRC_ALU: data_s = wb.wb_alu_result;
         default: data_s = wb.wb_alu_result;
      endcase
      commit_s = accept_s && !drop_s && wb.wb_regwrite && !rst;
   end

   // Register file storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (commit_s) begin
         regs_r[dest_s] <= data_s;
      end
   end

   // Availability scoreboard; the claim is assigned last so it wins over a
   // commit to the same index.
   always_ff @(posedge clk) begin
      if (rst) begin
         avail_r <= {NREGS{1'b1}};
      end else begin
         if (commit_s) begin
            avail_r[dest_s] <= 1'b1;
         end
         if (claim_valid) begin
            avail_r[claim_idx] <= 1'b0;
         end
      end
   end

   // Retired-write counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_cnt_r <= {CNT_W{1'b0}};
      end else if (commit_s) begin
         retired_cnt_r <= retired_cnt_r + CNT_W'(1);
      end
   end

   // Read ports with same-cycle commit bypass.
   always_comb begin
      ra_data  = regs_r[ra_idx];
      ra_avail = avail_r[ra_idx];
      rb_data  = regs_r[rb_idx];
      rb_avail = avail_r[rb_idx];
      if (commit_s && (dest_s == ra_idx)) begin
         ra_data  = data_s;
         ra_avail = 1'b1;
      end else begin
         ra_data  = regs_r[ra_idx];
         ra_avail = avail_r[ra_idx];
      end
      if (commit_s && (dest_s == rb_idx)) begin
         rb_data  = data_s;
         rb_avail = 1'b1;
      end else begin
         rb_data  = regs_r[rb_idx];
         rb_avail = avail_r[rb_idx];
      end
      retired_cnt = retired_cnt_r;
   end

`ifdef WB_TRACE_EN
   // Commit trace: destination, data and the register file as it stands
   // after this edge.
   always_ff @(posedge clk) begin
      if (commit_s) begin
         $display("wb commit r%0d <= %h", dest_s, data_s);
         for (int i = 0; i < NREGS; i++) begin
            $display("  r%0d = %h", i, (IDX_W'(i) == dest_s) ? data_s : regs_r[i]);
         end
         $display("");
      end
   end
`else
`endif

endmodule

// File: tb/tb_wb_regfile_commit.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile_commit
// Scoreboard bench: a behavioural model predicts read-port/status outputs for
// each cycle as stimulus is driven; predictions are queued and compared at the
// following falling edge, then the model advances on the rising edge.
// -----------------------------------------------------------------------------
module tb_wb_regfile_commit;

   localparam int DATA_W = 16;
   localparam int NREGS  = 16;
   localparam int IDX_W  = 4;
   localparam int SQ_W   = 2;
   localparam int CNT_W  = 32;

   logic              clk;
   logic              rst;
   logic              stall;
   logic              squash_set;
   logic [SQ_W-1:0]   squash_n;
   logic              claim_valid;
   logic [IDX_W-1:0]  claim_idx;
   logic [IDX_W-1:0]  ra_idx;
   logic [IDX_W-1:0]  rb_idx;
   logic [DATA_W-1:0] ra_data;
   logic [DATA_W-1:0] rb_data;
   logic              ra_avail;
   logic              rb_avail;
   logic              squash_busy;
   logic [CNT_W-1:0]  retired_cnt;

   wb_regfile_commit_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) wbif ();

   wb_regfile_commit #(
      .DATA_W (DATA_W), .NREGS (NREGS), .IDX_W (IDX_W), .SQ_W (SQ_W), .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .wb          (wbif),
      .squash_set  (squash_set),
      .squash_n    (squash_n),
      .claim_valid (claim_valid),
      .claim_idx   (claim_idx),
      .ra_idx      (ra_idx),
      .rb_idx      (rb_idx),
      .ra_data     (ra_data),
      .rb_data     (rb_data),
      .ra_avail    (ra_avail),
      .rb_avail    (rb_avail),
      .squash_busy (squash_busy),
      .retired_cnt (retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] ra_d;
      logic              ra_a;
      logic [DATA_W-1:0] rb_d;
      logic              rb_a;
      logic              busy;
      logic [CNT_W-1:0]  ret;
   } exp_t;

   exp_t sb_q[$];

   logic [DATA_W-1:0] m_regs [NREGS];
   logic [NREGS-1:0]  m_avail;
   logic [SQ_W-1:0]   m_cnt;
   logic [CNT_W-1:0]  m_ret;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) m_regs[i] = 16'h0000;
      m_avail = 16'hFFFF;
      m_cnt   = 2'd0;
      m_ret   = 32'd0;
   endtask

   task automatic beat(input logic v, input logic rw, input logic m2r, input logic rdst,
                       input logic [IDX_W-1:0] rs, input logic [IDX_W-1:0] rd,
                       input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem);
      wbif.wb_valid      = v;
      wbif.wb_regwrite   = rw;
      wbif.wb_memtoreg   = m2r;
      wbif.wb_regdst     = rdst;
      wbif.wb_rs         = rs;
      wbif.wb_rd         = rd;
      wbif.wb_alu_result = alu;
      wbif.wb_read_data  = mem;
   endtask

   task automatic idle();
      beat(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0000, 16'h0000);
      squash_set  = 1'b0;
      claim_valid = 1'b0;
      stall       = 1'b0;
   endtask

   // One clock: predict, compare at the falling edge, advance model at the rising edge.
   task automatic tick(input string tag);
      exp_t e;
      exp_t o;
      logic acc, drp, com;
      logic [IDX_W-1:0]  dst;
      logic [DATA_W-1:0] dat;
      acc = wbif.wb_valid && !stall;
      drp = acc && (m_cnt != 2'd0);
      com = acc && (m_cnt == 2'd0) && wbif.wb_regwrite && !rst;
      dst = wbif.wb_memtoreg ? wbif.wb_rs : (wbif.wb_regdst ? wbif.wb_rd : wbif.wb_rs);
      dat = wbif.wb_memtoreg ? wbif.wb_read_data : wbif.wb_alu_result;
      e.ra_d = (com && dst == ra_idx) ? dat : m_regs[ra_idx];
      e.ra_a = (com && dst == ra_idx) ? 1'b1 : m_avail[ra_idx];
      e.rb_d = (com && dst == rb_idx) ? dat : m_regs[rb_idx];
      e.rb_a = (com && dst == rb_idx) ? 1'b1 : m_avail[rb_idx];
      e.busy = (m_cnt != 2'd0);
      e.ret  = m_ret;
      sb_q.push_back(e);
      @(negedge clk);
      o = sb_q.pop_front();
      chk({tag, ".ra_data"},  {48'd0, ra_data},     {48'd0, o.ra_d});
      chk({tag, ".ra_avail"}, {63'd0, ra_avail},    {63'd0, o.ra_a});
      chk({tag, ".rb_data"},  {48'd0, rb_data},     {48'd0, o.rb_d});
      chk({tag, ".rb_avail"}, {63'd0, rb_avail},    {63'd0, o.rb_a});
      chk({tag, ".busy"},     {63'd0, squash_busy}, {63'd0, o.busy});
      chk({tag, ".retired"},  {32'd0, retired_cnt}, {32'd0, o.ret});
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (com) begin
            m_regs[dst]  = dat;
            m_avail[dst] = 1'b1;
            m_ret        = m_ret + 32'd1;
         end
         if (claim_valid) m_avail[claim_idx] = 1'b0;
         if (squash_set)  m_cnt = squash_n;
         else if (drp)    m_cnt = m_cnt - 2'd1;
      end
      #1;
   endtask

   task automatic sweep(input string tag);
      idle();
      for (int i = 0; i < NREGS; i += 2) begin
         ra_idx = IDX_W'(i);
         rb_idx = IDX_W'(i + 1);
         tick(tag);
      end
   endtask

   // Simple rd-destination commit.
   task automatic wr_rd(input logic [IDX_W-1:0] rd, input logic [DATA_W-1:0] v);
      beat(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, rd, v, 16'h5A5A);
   endtask

   initial begin
      rst = 1'b1;
      squash_n = 2'd0;
      claim_idx = 4'd0;
      ra_idx = 4'd0;
      rb_idx = 4'd0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;

      sweep("reset");

      // regdst commit to r5, bypass on ra, then stored value
      wr_rd(4'd5, 16'h1234); ra_idx = 4'd5; rb_idx = 4'd0; tick("rd5");
      idle(); tick("rd5_hold");

      // load writes rs with read_data, not rd, not alu
      beat(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 4'd9, 16'h0001, 16'hBEEF);
      ra_idx = 4'd3; rb_idx = 4'd9; tick("load_r3");
      idle(); tick("load_hold");

      // regdst=0 picks rs with alu data
      beat(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 4'd8, 16'h0606, 16'hDEAD);
      ra_idx = 4'd6; rb_idx = 4'd8; tick("rs6");
      // regwrite=0: nothing changes
      beat(1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 4'd8, 16'h7777, 16'h7777);
      tick("norw");
      idle(); tick("norw_hold");

      // squash 2 then three beats: only r4 written
      squash_set = 1'b1; squash_n = 2'd2; tick("sq_set");
      squash_set = 1'b0;
      ra_idx = 4'd1; rb_idx = 4'd2;
      wr_rd(4'd1, 16'h0001); tick("sq_b1");
      wr_rd(4'd2, 16'h0002); tick("sq_b2");
      ra_idx = 4'd4; wr_rd(4'd4, 16'h0004); tick("sq_b3");
      idle(); tick("sq_hold");

      // squash_set alongside a beat: beat judged against old counter (commits)
      wr_rd(4'd10, 16'hA0A0); squash_set = 1'b1; squash_n = 2'd1;
      ra_idx = 4'd10; rb_idx = 4'd11; tick("sq_same");
      squash_set = 1'b0; wr_rd(4'd11, 16'hB0B0); tick("sq_drop11");
      wr_rd(4'd12, 16'hC0C0); ra_idx = 4'd12; tick("sq_c12");

      // stalls hold the counter; then two unstalled beats both dropped
      idle(); squash_set = 1'b1; squash_n = 2'd2; tick("st_set");
      squash_set = 1'b0; ra_idx = 4'd13; rb_idx = 4'd14;
      for (int i = 0; i < 3; i++) begin
         wr_rd(4'd13, 16'hD0D0); stall = 1'b1; tick("st_stall");
      end
      stall = 1'b0;
      wr_rd(4'd13, 16'hD1D1); tick("st_drop1");
      wr_rd(4'd13, 16'hD2D2); tick("st_drop2");
      wr_rd(4'd14, 16'hE0E0); tick("st_commit");

      // squash_n=0 clears a pending squash
      idle(); squash_set = 1'b1; squash_n = 2'd3; tick("clr_set");
      squash_n = 2'd0; tick("clr_zero");
      squash_set = 1'b0; wr_rd(4'd15, 16'hF0F0); ra_idx = 4'd15; tick("clr_commit");

      // claim and commit to r7 together: data written, avail ends 0
      wr_rd(4'd7, 16'h00AA); claim_valid = 1'b1; claim_idx = 4'd7;
      ra_idx = 4'd7; rb_idx = 4'd5; tick("claim7");
      idle(); tick("claim7_after");
      // claim alone: read ports unaffected until next cycle
      claim_valid = 1'b1; claim_idx = 4'd5; tick("claim5");
      idle(); tick("claim5_after");
      wr_rd(4'd5, 16'h5555); tick("recommit5");
      idle(); tick("recommit5_after");

      // reset overrides commit, claim and squash_set
      rst = 1'b1; wr_rd(4'd2, 16'hFFFF); squash_set = 1'b1; squash_n = 2'd3;
      claim_valid = 1'b1; claim_idx = 4'd0; tick("rst_mid");
      rst = 1'b0;
      sweep("post_rst");

      // random traffic against the model
      for (int n = 0; n < 300; n++) begin
         beat(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
              1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
              16'($urandom), 16'($urandom));
         stall       = ($urandom_range(0, 5) == 0);
         squash_set  = ($urandom_range(0, 9) == 0);
         squash_n    = 2'($urandom);
         claim_valid = ($urandom_range(0, 3) == 0);
         claim_idx   = 4'($urandom);
         ra_idx      = 4'($urandom);
         rb_idx      = 4'($urandom);
         rst         = ($urandom_range(0, 99) == 0);
         tick("rand");
      end
      rst = 1'b0;
      sweep("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
